// File: rtl/frame_deserializer_if.sv
// Bus bundle for frame_deserializer: byte input side and parallel frame output side.
// The master modport is the link/consumer side, the slave modport is the deserializer.
interface frame_deserializer_if #(
   parameter int NUM_CHANNELS = 4
);

   logic [7:0]                  din;
   logic                        din_valid;
   logic [8*NUM_CHANNELS-1:0]   dout;
   logic                        dout_valid;
   logic                        frame_err;
   logic                        busy;
   logic [15:0]                 good_cnt;

   modport master (
      output din,
      output din_valid,
      input  dout,
      input  dout_valid,
      input  frame_err,
      input  busy,
      input  good_cnt
   );

   modport slave (
      input  din,
      input  din_valid,
      output dout,
      output dout_valid,
      output frame_err,
      output busy,
      output good_cnt
   );

endinterface

// File: rtl/frame_deserializer.sv
// frame_deserializer: receive side of the 8-bit framed channel link.
// Frame format is HEADER, NUM_CHANNELS data bytes, FOOTER. The block hunts for
// HEADER, gathers the data bytes into a shadow buffer, checks FOOTER and then
// publishes the whole frame on dout with a one-cycle dout_valid strobe.
// Optional feature macro: FRAME_TIMEOUT_EN enables an idle-gap timeout of
// TIMEOUT_CYCLES cycles while a frame is in progress.
module frame_deserializer #(
   parameter logic [7:0] HEADER         = 8'hAA,
   parameter logic [7:0] FOOTER         = 8'hFF,
   parameter int         NUM_CHANNELS   = 4,
   parameter int         TIMEOUT_CYCLES = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   frame_deserializer_if.slave  bus
);

   localparam int CW = $clog2(NUM_CHANNELS + 1);
   localparam int DW = 8 * NUM_CHANNELS;

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_DATA,
      ST_FOOTER
   } state_t;

   // Reject parameter values that would give a meaningless frame or timeout.
   if (NUM_CHANNELS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("frame_deserializer: NUM_CHANNELS and TIMEOUT_CYCLES must be >= 1");
   end

   state_t          state, state_n;
   logic [CW-1:0]   ch, ch_n;
   logic [DW-1:0]   shadow, shadow_n;
   logic [DW-1:0]   dout_n;
   logic            dout_valid_n;
   logic            frame_err_n;
   logic            busy_n;
   logic [15:0]     good_cnt_n;
   logic            timeout_hit;

`ifdef FRAME_TIMEOUT_EN
   localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

   logic [GW-1:0]   gap_cnt;

   // The gap counter only advances on idle cycles inside a frame; any byte or a
   // return to HUNT clears it so each frame gets a fresh idle allowance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt <= '0;
      end else if (state_n == ST_HUNT || bus.din_valid) begin
         gap_cnt <= '0;
      end else begin
         gap_cnt <= gap_cnt + GW'(1);
      end
   end

   // This idle cycle is the TIMEOUT_CYCLES-th consecutive one inside a frame.
   assign timeout_hit = (state != ST_HUNT) && !bus.din_valid &&
                        (gap_cnt == GW'(TIMEOUT_CYCLES - 1));
`else
   // Without the timeout a partial frame may wait forever for its next byte.
   assign timeout_hit = 1'b0;
`endif

   // State, buffer and every output are registered so downstream logic sees clean pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_HUNT;
         ch             <= '0;
         shadow         <= '0;
         bus.dout       <= '0;
         bus.dout_valid <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.busy       <= 1'b0;
         bus.good_cnt   <= '0;
      end else begin
         state          <= state_n;
         ch             <= ch_n;
         shadow         <= shadow_n;
         bus.dout       <= dout_n;
         bus.dout_valid <= dout_valid_n;
         bus.frame_err  <= frame_err_n;
         bus.busy       <= busy_n;
         bus.good_cnt   <= good_cnt_n;
      end
   end

   // Next-state and next-output decode; only valid bytes move the machine, idle cycles hold it.
   always_comb begin
      state_n      = state;
      ch_n         = ch;
      shadow_n     = shadow;
      dout_n       = bus.dout;
      dout_valid_n = 1'b0;
      frame_err_n  = 1'b0;
      good_cnt_n   = bus.good_cnt;

      if (bus.din_valid) begin
         case (state)
            ST_HUNT: begin
               if (bus.din == HEADER) begin
                  state_n = ST_DATA;
                  ch_n    = '0;
               end
            end

            ST_DATA: begin
               // Data bytes are stored as-is; HEADER/FOOTER values are legal payload.
               shadow_n[8*int'(ch) +: 8] = bus.din;
               ch_n = ch + CW'(1);
               if (ch == CW'(NUM_CHANNELS - 1)) begin
                  state_n = ST_FOOTER;
               end
            end

            ST_FOOTER: begin
               if (bus.din == FOOTER) begin
                  dout_n       = shadow;
                  dout_valid_n = 1'b1;
                  good_cnt_n   = bus.good_cnt + 16'd1;
                  state_n      = ST_HUNT;
               end else if (bus.din == HEADER) begin
                  // A header where the footer belongs most likely starts a new
                  // frame, so restart collection immediately instead of hunting.
                  frame_err_n = 1'b1;
                  state_n     = ST_DATA;
                  ch_n        = '0;
               end else begin
                  frame_err_n = 1'b1;
                  state_n     = ST_HUNT;
               end
            end

            default: begin
               state_n = ST_HUNT;
            end
         endcase
      end else if (timeout_hit) begin
         frame_err_n = 1'b1;
         state_n     = ST_HUNT;
         ch_n        = '0;
      end

      busy_n = (state_n != ST_HUNT);
   end

endmodule

// File: tb/tb_frame_deserializer.sv
// Testbench for frame_deserializer: table of frame vectors plus hand-written
// corner sequences (back-to-back frames, long gaps / timeout, mid-frame reset).
// A scoreboard queue holds the expected dout of every good frame; the monitor
// pops it on each dout_valid pulse.
module tb_frame_deserializer;

   localparam int NCH = 4;
   localparam int TMO = 8;

   typedef struct {
      logic [127:0] bytes;      // byte i at [8i+:8], first byte in the low bits
      int           len;
      int           gap;        // idle cycles between consecutive bytes
      int           exp_good;
      int           exp_err;
      logic [31:0]  exp_dout;   // dout value held after the vector
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;

   int n_checks = 0;
   int n_fail   = 0;
   int dv_seen  = 0;
   int fe_seen  = 0;
   int exp_good_cnt = 0;

   logic [31:0] exp_q[$];
   vec_t        vecs[6];

   always #5 clk = ~clk;

   frame_deserializer_if #(.NUM_CHANNELS(NCH)) bus ();

   frame_deserializer #(
      .HEADER         (8'hAA),
      .FOOTER         (8'hFF),
      .NUM_CHANNELS   (NCH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Monitor: samples on the falling edge, counts pulses and scores each good frame.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.dout_valid && bus.frame_err) begin
            check_output("dout_valid/frame_err exclusive", 32'd1, 32'd0);
         end
         if (bus.dout_valid) begin
            dv_seen++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("[TB] FAIL unexpected dout_valid: got dout %h, expected no pulse", bus.dout);
            end else begin
               check_output("dout at pulse", bus.dout, exp_q.pop_front());
            end
         end
         if (bus.frame_err) fe_seen++;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_byte(input logic [7:0] b);
      bus.din       = b;
      bus.din_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.din_valid = 1'b0;
      bus.din       = 8'h00;
   endtask

   task automatic apply_stimulus(input vec_t v, input int idx);
      int dv0, fe0;
      dv0 = dv_seen;
      fe0 = fe_seen;
      if (v.exp_good == 1) exp_q.push_back(v.exp_dout);
      exp_good_cnt += v.exp_good;
      for (int i = 0; i < v.len; i++) begin
         drive_byte(v.bytes[8*i +: 8]);
         if (i < v.len - 1) idle(v.gap);
      end
      idle(2);
      check_output($sformatf("vec%0d dout_valid pulses", idx), 32'(dv_seen - dv0), 32'(v.exp_good));
      check_output($sformatf("vec%0d frame_err pulses", idx), 32'(fe_seen - fe0), 32'(v.exp_err));
      check_output($sformatf("vec%0d dout", idx), bus.dout, v.exp_dout);
      check_output($sformatf("vec%0d good_cnt", idx), 32'(bus.good_cnt), 32'(exp_good_cnt));
      check_output($sformatf("vec%0d busy", idx), 32'(bus.busy), 32'd0);
      check_output($sformatf("vec%0d scoreboard drained", idx), 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, " dout"}, bus.dout, 32'd0);
      check_output({tag, " dout_valid"}, 32'(bus.dout_valid), 32'd0);
      check_output({tag, " frame_err"}, 32'(bus.frame_err), 32'd0);
      check_output({tag, " busy"}, 32'(bus.busy), 32'd0);
      check_output({tag, " good_cnt"}, 32'(bus.good_cnt), 32'd0);
   endtask

   initial begin
      int dv0, fe0;

      // Vector bytes are written last-byte-first so byte 0 lands in the low bits.
      vecs[0] = '{128'({8'hFF, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAA}), 6, 0, 1, 0, 32'h44332211};
      vecs[1] = '{128'({8'hFF, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAA}), 6, 3, 1, 0, 32'h44332211};
      vecs[2] = '{128'({8'hFF, 8'h04, 8'h03, 8'h02, 8'h01, 8'hAA, 8'h55, 8'h00}), 8, 0, 1, 0, 32'h04030201};
      vecs[3] = '{128'({8'hFF, 8'h08, 8'h07, 8'h06, 8'h05, 8'hAA, 8'h04, 8'h03, 8'h02, 8'h01, 8'hAA}),
                  11, 0, 1, 1, 32'h08070605};
      vecs[4] = '{128'({8'h7E, 8'h04, 8'h03, 8'h02, 8'h01, 8'hAA}), 6, 0, 0, 1, 32'h08070605};
      // Channel k sits at dout[8k+7:8k]: data FF AA FF AA gives AAFFAAFF.
      vecs[5] = '{128'({8'hFF, 8'hAA, 8'hFF, 8'hAA, 8'hFF, 8'hAA}), 6, 0, 1, 0, 32'hAAFFAAFF};

      rst_n         = 1'b0;
      bus.din       = 8'h00;
      bus.din_valid = 1'b0;
      idle(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      idle(2);

      for (int i = 0; i < 6; i++) apply_stimulus(vecs[i], i);

      // Back-to-back frames: second header immediately follows the first footer.
      dv0 = dv_seen;
      exp_q.push_back(32'h04030201);
      exp_q.push_back(32'h08070605);
      exp_good_cnt += 2;
      foreach (vecs[0].bytes[i]) begin end
      drive_byte(8'hAA); drive_byte(8'h01); drive_byte(8'h02); drive_byte(8'h03);
      drive_byte(8'h04); drive_byte(8'hFF);
      drive_byte(8'hAA); drive_byte(8'h05); drive_byte(8'h06); drive_byte(8'h07);
      drive_byte(8'h08); drive_byte(8'hFF);
      idle(2);
      check_output("b2b pulses", 32'(dv_seen - dv0), 32'd2);
      check_output("b2b good_cnt", 32'(bus.good_cnt), 32'(exp_good_cnt));
      check_output("b2b scoreboard drained", 32'(exp_q.size()), 32'd0);

      // Long idle gap inside a frame.
      dv0 = dv_seen;
      fe0 = fe_seen;
      drive_byte(8'hAA);
      drive_byte(8'h01);
`ifdef FRAME_TIMEOUT_EN
      idle(TMO);
      idle(2);
      check_output("timeout frame_err pulses", 32'(fe_seen - fe0), 32'd1);
      check_output("timeout busy", 32'(bus.busy), 32'd0);
      check_output("timeout dout held", bus.dout, 32'h08070605);
      check_output("timeout no dout_valid", 32'(dv_seen - dv0), 32'd0);
`else
      idle(3 * TMO);
      check_output("long gap busy", 32'(bus.busy), 32'd1);
      check_output("long gap no frame_err", 32'(fe_seen - fe0), 32'd0);
      exp_q.push_back(32'h04030201);
      exp_good_cnt += 1;
      drive_byte(8'h02); drive_byte(8'h03); drive_byte(8'h04); drive_byte(8'hFF);
      idle(2);
      check_output("long gap pulses", 32'(dv_seen - dv0), 32'd1);
      check_output("long gap good_cnt", 32'(bus.good_cnt), 32'(exp_good_cnt));
`endif

      // Reset in the middle of a frame discards it without an error pulse.
      fe0 = fe_seen;
      drive_byte(8'hAA);
      drive_byte(8'h01);
      drive_byte(8'h02);
      check_output("pre-reset busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #2;
      check_reset_outputs("mid-frame reset");
      idle(2);
      rst_n = 1'b1;
      exp_good_cnt = 0;
      idle(1);
      check_output("mid-frame reset no frame_err", 32'(fe_seen - fe0), 32'd0);

      // The first frame after reset must start from channel 0.
      dv0 = dv_seen;
      exp_q.push_back(32'hDDCCBBAA);
      exp_good_cnt += 1;
      drive_byte(8'hAA); drive_byte(8'hAA); drive_byte(8'hBB); drive_byte(8'hCC);
      drive_byte(8'hDD); drive_byte(8'hFF);
      idle(2);
      check_output("post-reset pulses", 32'(dv_seen - dv0), 32'd1);
      check_output("post-reset good_cnt", 32'(bus.good_cnt), 32'(exp_good_cnt));
      check_output("post-reset scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog so the bench always terminates.
   initial begin
      #200000;
      n_checks++;
      n_fail++;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected test to finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
